// File: rtl/instr_mem_loader_pkg.sv
// Purpose: shared types and constants for the instruction memory loader.
// Latency: n/a (declarations only).
// Backpressure: n/a (declarations only).
package instr_mem_loader_pkg;

    // Loader FSM encoding.
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LOAD  = 2'd1,
        ST_READY = 2'd2
    } state_t;

    // Widest instruction word supported by the default halt constant.
    localparam int MAX_DATA_W = 256;

    // Default halt word is all-ones; the top slices it down to DATA_W.
    localparam logic [MAX_DATA_W-1:0] HALT_ALL_ONES = '1;

endpackage

// File: rtl/instr_mem_loader_if.sv
// Purpose: load-byte stream, load status and instruction fetch bundle.
// Latency: n/a (wires only).
// Backpressure: o_byte_ready gates i_byte_valid; fetch side has none.
// Ports: master drives load/fetch requests, slave (the loader) drives status and o_instr.
interface instr_mem_loader_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 11
);
    logic              i_load_start;
    logic              i_byte_valid;
    logic [7:0]        i_byte;
    logic              o_byte_ready;
    logic              o_load_done;
    logic              o_overflow;
    logic [ADDR_W:0]   o_prog_len;
    logic              i_fetch_en;
    logic [DATA_W-1:0] i_pc;
    logic [DATA_W-1:0] o_instr;
    logic              o_instr_valid;

    modport master (
        output i_load_start, i_byte_valid, i_byte, i_fetch_en, i_pc,
        input  o_byte_ready, o_load_done, o_overflow, o_prog_len, o_instr, o_instr_valid
    );

    modport slave (
        input  i_load_start, i_byte_valid, i_byte, i_fetch_en, i_pc,
        output o_byte_ready, o_load_done, o_overflow, o_prog_len, o_instr, o_instr_valid
    );
endinterface

// File: rtl/instr_mem_loader_imem_ram.sv
// Purpose: instruction storage, one synchronous write port and one registered read port.
// Latency: write lands on the edge; read data appears one edge after rd_en.
// Backpressure: none; rd_data holds while rd_en is low.
// Ports: clk; wr_en/wr_addr/wr_data write port; rd_en/rd_addr read request; rd_data registered output.
module imem_ram #(
    parameter int DATA_W = 32,
    parameter int DEPTH  = 2048,
    parameter int ADDR_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              rd_en,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [DATA_W-1:0] rd_data
);
    // No reset on the array or the read register so the tools can map to block RAM.
    logic [DATA_W-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
        if (rd_en) begin
            rd_data <= mem[rd_addr];
        end
    end
endmodule

// File: rtl/instr_mem_loader.sv
// Purpose: packs a big-endian byte stream into instruction memory until HALT_WORD, then serves fetches.
// Latency: word written on the edge accepting its last byte; fetch data valid one cycle after i_fetch_en.
// Backpressure: o_byte_ready high only while loading; fetches accepted every cycle in READY.
// Ports: i_clk, i_rst_n (async active-low); bus = instr_mem_loader_if.slave (load stream, status, fetch).
module instr_mem_loader
    import instr_mem_loader_pkg::*;
#(
    parameter int                DATA_W    = 32,
    parameter int                DEPTH     = 2048,
    parameter logic [DATA_W-1:0] HALT_WORD = HALT_ALL_ONES[DATA_W-1:0]
) (
    input  logic            i_clk,
    input  logic            i_rst_n,
    instr_mem_loader_if.slave bus
);
    localparam int ADDR_W = $clog2(DEPTH);
    localparam int BPW    = DATA_W / 8;
    localparam int CNT_W  = (BPW > 1) ? $clog2(BPW) : 1;

    localparam logic [CNT_W-1:0] LAST_BYTE = CNT_W'(BPW - 1);
    localparam logic [ADDR_W:0]  DEPTH_CNT = (ADDR_W + 1)'(DEPTH);

    state_t            state;
    logic [CNT_W-1:0]  byte_cnt;
    logic [DATA_W-1:0] word_q;
    logic [ADDR_W:0]   wr_ptr;
    // Forces o_instr to zero after reset and for fetches past the program end,
    // without needing a reset or mux inside the RAM read register.
    logic              instr_zero_q;

    logic [DATA_W+7:0] word_cat;
    logic [DATA_W-1:0] word_next;
    logic              byte_fire;
    logic              word_fire;
    logic              fetch_fire;
    logic [ADDR_W-1:0] fetch_idx;
    logic [DATA_W-1:0] rd_data;

    // A restart on the same edge wins, so the byte is not consumed.
    assign byte_fire  = (state == ST_LOAD) && bus.i_byte_valid && !bus.i_load_start;
    assign word_fire  = byte_fire && (byte_cnt == LAST_BYTE);

    // Shift in at the bottom: the first byte ends up in the top lane.
    assign word_cat   = {word_q, bus.i_byte};
    assign word_next  = word_cat[DATA_W-1:0];

    assign fetch_fire = (state == ST_READY) && bus.i_fetch_en;
    assign fetch_idx  = bus.i_pc[ADDR_W+1:2];

    imem_ram #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W)
    ) u_imem_ram (
        .clk     (i_clk),
        .wr_en   (word_fire),
        .wr_addr (wr_ptr[ADDR_W-1:0]),
        .wr_data (word_next),
        .rd_en   (fetch_fire),
        .rd_addr (fetch_idx),
        .rd_data (rd_data)
    );

    assign bus.o_instr = instr_zero_q ? '0 : rd_data;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state             <= ST_IDLE;
            byte_cnt          <= '0;
            word_q            <= '0;
            wr_ptr            <= '0;
            instr_zero_q      <= 1'b1;
            bus.o_byte_ready  <= 1'b0;
            bus.o_load_done   <= 1'b0;
            bus.o_overflow    <= 1'b0;
            bus.o_prog_len    <= '0;
            bus.o_instr_valid <= 1'b0;
        end else begin
            bus.o_instr_valid <= fetch_fire;
            if (fetch_fire) begin
                instr_zero_q <= ({1'b0, fetch_idx} >= bus.o_prog_len);
            end

            if (bus.i_load_start) begin
                // Start or restart from any state; any partial word is dropped.
                state            <= ST_LOAD;
                bus.o_byte_ready <= 1'b1;
                byte_cnt         <= '0;
                word_q           <= '0;
                wr_ptr           <= '0;
                bus.o_prog_len   <= '0;
                bus.o_load_done  <= 1'b0;
                bus.o_overflow   <= 1'b0;
            end else if (byte_fire) begin
                word_q <= word_next;
                if (byte_cnt == LAST_BYTE) begin
                    byte_cnt <= '0;
                    wr_ptr   <= wr_ptr + 1'b1;
                    if (word_next == HALT_WORD) begin
                        // Halt word itself is stored and counted.
                        state            <= ST_READY;
                        bus.o_byte_ready <= 1'b0;
                        bus.o_load_done  <= 1'b1;
                        bus.o_prog_len   <= wr_ptr + 1'b1;
                    end else if (wr_ptr == DEPTH_CNT - 1'b1) begin
                        // Last slot filled without a halt: stop before wrapping.
                        state            <= ST_READY;
                        bus.o_byte_ready <= 1'b0;
                        bus.o_overflow   <= 1'b1;
                        bus.o_prog_len   <= DEPTH_CNT;
                    end
                end else begin
                    byte_cnt <= byte_cnt + 1'b1;
                end
            end
        end
    end
endmodule

// File: tb/tb_instr_mem_loader.sv
module tb_instr_mem_loader;
    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;
    logic [31:0] exp_q[$];
    logic [31:0] mon_exp;

    instr_mem_loader_if #(.DATA_W(32), .ADDR_W(2)) bus ();

    instr_mem_loader #(
        .DATA_W (32),
        .DEPTH  (4)
    ) dut (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .bus     (bus)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Scoreboard monitor: every valid fetch result must match the oldest pending expectation.
    always @(negedge clk) begin
        if (rst_n && bus.o_instr_valid) begin
            n_checks++;
            if (exp_q.size() == 0) begin
                n_fail++;
                $display("FAIL fetch_unexpected: got 0x%0h valid, expected no fetch result", bus.o_instr);
            end else begin
                mon_exp = exp_q.pop_front();
                if (bus.o_instr !== mon_exp) begin
                    n_fail++;
                    $display("FAIL fetch_data: got 0x%0h, expected 0x%0h", bus.o_instr, mon_exp);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic load_start();
        bus.i_load_start = 1'b1;
        tick();
        bus.i_load_start = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b);
        bus.i_byte_valid = 1'b1;
        bus.i_byte       = b;
        tick();
        bus.i_byte_valid = 1'b0;
    endtask

    task automatic send_word(input logic [31:0] w);
        send_byte(w[31:24]);
        send_byte(w[23:16]);
        send_byte(w[15:8]);
        send_byte(w[7:0]);
    endtask

    task automatic fetch(input logic [31:0] pc, input logic [31:0] exp);
        bus.i_fetch_en = 1'b1;
        bus.i_pc       = pc;
        exp_q.push_back(exp);
        tick();
        bus.i_fetch_en = 1'b0;
    endtask

    task automatic check_idle_outputs(input string tag);
        check({tag, "_byte_ready"},  {31'd0, bus.o_byte_ready},  32'd0);
        check({tag, "_load_done"},   {31'd0, bus.o_load_done},   32'd0);
        check({tag, "_overflow"},    {31'd0, bus.o_overflow},    32'd0);
        check({tag, "_prog_len"},    {29'd0, bus.o_prog_len},    32'd0);
        check({tag, "_instr"},       bus.o_instr,                32'd0);
        check({tag, "_instr_valid"}, {31'd0, bus.o_instr_valid}, 32'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.i_load_start = 1'b0;
        bus.i_byte_valid = 1'b0;
        bus.i_byte       = 8'h00;
        bus.i_fetch_en   = 1'b0;
        bus.i_pc         = 32'h0;

        // Reset state
        tick();
        tick();
        check_idle_outputs("reset");
        rst_n = 1'b1;
        tick();

        // Basic load: 0x00000001 then halt
        load_start();
        check("load_byte_ready", {31'd0, bus.o_byte_ready}, 32'd1);
        send_word(32'h0000_0001);
        send_word(32'hFFFF_FFFF);
        check("basic_load_done",  {31'd0, bus.o_load_done},  32'd1);
        check("basic_prog_len",   {29'd0, bus.o_prog_len},   32'd2);
        check("basic_overflow",   {31'd0, bus.o_overflow},   32'd0);
        check("basic_byte_ready", {31'd0, bus.o_byte_ready}, 32'd0);
        fetch(32'h0, 32'h0000_0001);
        fetch(32'h8, 32'h0000_0000);      // past program end -> NOP
        fetch(32'h3, 32'h0000_0001);      // low pc bits ignored
        fetch(32'h4, 32'hFFFF_FFFF);      // halt word is stored

        // Back-to-back fetches, then stall holds the output
        bus.i_fetch_en = 1'b1;
        bus.i_pc = 32'h0; exp_q.push_back(32'h0000_0001); tick();
        bus.i_pc = 32'h4; exp_q.push_back(32'hFFFF_FFFF); tick();
        bus.i_fetch_en = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("stall_instr_hold", bus.o_instr, 32'hFFFF_FFFF);
            check("stall_valid_low",  {31'd0, bus.o_instr_valid}, 32'd0);
        end

        // Restart after 6 bytes; a byte on the restart edge is dropped
        load_start();
        send_byte(8'hAA); send_byte(8'hBB); send_byte(8'hCC);
        send_byte(8'hDD); send_byte(8'hEE); send_byte(8'hFF);
        bus.i_byte_valid = 1'b1;
        bus.i_byte       = 8'h99;
        load_start();
        bus.i_byte_valid = 1'b0;
        send_word(32'h1234_5678);
        send_word(32'hFFFF_FFFF);
        check("restart_load_done", {31'd0, bus.o_load_done}, 32'd1);
        check("restart_prog_len",  {29'd0, bus.o_prog_len},  32'd2);
        fetch(32'h0, 32'h1234_5678);
        fetch(32'h4, 32'hFFFF_FFFF);

        // Overflow: four non-halt words fill DEPTH=4, extra bytes refused
        load_start();
        send_word(32'h0102_0304);
        send_word(32'h0506_0708);
        send_word(32'h090A_0B0C);
        send_word(32'h0D0E_0F10);
        check("ovf_overflow",   {31'd0, bus.o_overflow},   32'd1);
        check("ovf_load_done",  {31'd0, bus.o_load_done},  32'd0);
        check("ovf_prog_len",   {29'd0, bus.o_prog_len},   32'd4);
        check("ovf_byte_ready", {31'd0, bus.o_byte_ready}, 32'd0);
        send_word(32'hDEAD_BEEF);
        check("ovf_still_not_ready", {31'd0, bus.o_byte_ready}, 32'd0);
        fetch(32'h0, 32'h0102_0304);
        fetch(32'h4, 32'h0506_0708);
        fetch(32'h8, 32'h090A_0B0C);
        fetch(32'hC, 32'h0D0E_0F10);

        // Reset mid-word
        load_start();
        send_byte(8'h55);
        send_byte(8'h66);
        rst_n = 1'b0;
        #1;
        check_idle_outputs("midreset");
        tick();
        rst_n = 1'b1;
        bus.i_byte_valid = 1'b1;
        bus.i_byte       = 8'h77;
        bus.i_fetch_en   = 1'b1;
        bus.i_pc         = 32'h0;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("postreset_byte_ready",  {31'd0, bus.o_byte_ready},  32'd0);
            check("postreset_instr_valid", {31'd0, bus.o_instr_valid}, 32'd0);
            check("postreset_instr",       bus.o_instr,                32'd0);
        end
        bus.i_byte_valid = 1'b0;
        bus.i_fetch_en   = 1'b0;
        load_start();
        send_word(32'hABCD_EF01);
        send_word(32'hFFFF_FFFF);
        check("reload_prog_len", {29'd0, bus.o_prog_len}, 32'd2);
        fetch(32'h0, 32'hABCD_EF01);
        fetch(32'h8, 32'h0000_0000);      // stale word beyond program end stays hidden

        tick();
        tick();
        check("scoreboard_drained", exp_q.size(), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/instr_mem_loader.md
INSTR_MEM_LOADER -- requirements
Module: instr_mem_loader

Interface
REQ-001 SHALL have parameter DATA_W, default 32, instruction word width in bits (multiple of 8).
REQ-002 SHALL have parameter DEPTH, default 2048, number of instruction words; ADDR_W = clog2(DEPTH) is derived as a localparam.
REQ-003 SHALL have parameter HALT_WORD, default all-ones of DATA_W, the word that terminates a program load.
REQ-004 SHALL have a single clock and an asynchronous active-low reset, as below.
REQ-005 i_clk  input  1  rising-edge clock for all state.
REQ-006 i_rst_n  input  1  asynchronous active-low reset.
REQ-007 i_load_start  input  1  one-cycle pulse; starts or restarts a program load.
REQ-008 i_byte_valid  input  1  a load byte is present on i_byte.
REQ-009 i_byte  input  8  load byte from the debug/UART path.
REQ-010 o_byte_ready  output  1  a byte is accepted when i_byte_valid && o_byte_ready at a rising edge.
REQ-011 o_load_done  output  1  program loaded and terminated by HALT_WORD.
REQ-012 o_overflow  output  1  DEPTH words were written without a HALT_WORD.
REQ-013 o_prog_len  output  ADDR_W+1  number of words written in the last load.
REQ-014 i_fetch_en  input  1  fetch request; low means a pipeline stall.
REQ-015 i_pc  input  DATA_W  byte address of the instruction to fetch.
REQ-016 o_instr  output  DATA_W  fetched instruction.
REQ-017 o_instr_valid  output  1  o_instr was updated by a fetch on the previous edge.

Function
REQ-018 SHALL implement an FSM with states IDLE, LOAD and READY.
REQ-019 In IDLE, i_load_start SHALL go to LOAD and clear the byte counter, write pointer, o_prog_len, o_load_done and o_overflow.
REQ-020 o_byte_ready SHALL be 1 exactly when the state is LOAD.
REQ-021 In LOAD, accepted bytes SHALL be packed big-endian: the first byte goes to bits [DATA_W-1:DATA_W-8].
REQ-022 On the edge that accepts the last byte of a word, the word SHALL be written to mem[wr_ptr] and wr_ptr SHALL increment; no additional latency.
REQ-023 If that word equals HALT_WORD, it SHALL still be written; on the same edge the FSM SHALL go to READY, o_load_done SHALL become 1 and o_prog_len SHALL become wr_ptr+1.
REQ-024 If wr_ptr reaches DEPTH without a HALT_WORD, the FSM SHALL go to READY with o_overflow=1, o_load_done=0 and o_prog_len=DEPTH; no write may wrap to address 0.
REQ-025 i_load_start in LOAD or READY SHALL restart the load per REQ-019 and discard any partial word.
REQ-026 i_load_start SHALL take priority over a byte accepted on the same edge; that byte is discarded.
REQ-027 In READY, i_fetch_en=1 at edge N SHALL load o_instr at edge N with mem[i_pc[ADDR_W+1:2]], and o_instr_valid SHALL be 1 for the following cycle (1-cycle latency).
REQ-028 i_pc[1:0] SHALL be ignored.
REQ-029 A fetch whose word index is >= o_prog_len SHALL return 0 (NOP) with o_instr_valid=1.
REQ-030 When i_fetch_en=0, or the state is not READY, o_instr SHALL hold its value and o_instr_valid SHALL be 0.
REQ-031 Back-to-back fetches SHALL sustain one instruction per cycle.

Reset
REQ-032 On i_rst_n=0, the state SHALL be IDLE and every output SHALL be 0, including o_instr and o_prog_len.
REQ-033 Reset SHALL NOT clear the memory array; a reset during LOAD SHALL discard the partial word, and the words already written remain but are unreachable until the next load completes.

Structure
REQ-034 The FSM state encodings and the default HALT_WORD SHALL live in the shared project package.
REQ-035 The storage array SHALL be a sub-module imem_ram (one synchronous write port, one registered read port) so that it infers block RAM.

Verification
REQ-036 Load bytes 00 00 00 01 / FF FF FF FF -> mem[0]=0x00000001, o_load_done=1, o_prog_len=2; fetch pc=0 -> o_instr=0x00000001 one cycle later.
REQ-037 Fetch pc=0x8 after REQ-036 -> o_instr=0x00000000, o_instr_valid=1.
REQ-038 Fetch pcs 0x0, 0x4 back-to-back, then i_fetch_en=0 for 3 cycles -> two valid outputs, then o_instr holds with o_instr_valid=0.
REQ-039 DEPTH=4 with 16 non-halt bytes plus 4 more -> o_overflow=1, o_prog_len=4, extra bytes not written, mem[0] unchanged.
REQ-040 Assert i_load_start after 6 bytes, then load 12 34 56 78 + HALT_WORD -> mem[0]=0x12345678, o_prog_len=2.
REQ-041 Assert i_rst_n low mid-word -> all outputs 0, state IDLE, o_byte_ready=0 until the next i_load_start.
